// File: rtl/rob_commit_unit.sv
// Retire stage controller: consumes the ROB head in order, writing ALU results
// to the register file, issuing stores through a req/ack handshake, and
// freezing on HALT until reset.
module rob_commit_unit #(
    parameter int unsigned ROB_ADDR_SIZE  = 5,
    parameter int unsigned DEST_ADDR_SIZE = 4,
    parameter int unsigned INS_TYPE_SIZE  = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [ROB_ADDR_SIZE-1:0]  head_id_i,
    input  logic [ROB_ADDR_SIZE-1:0]  tail_id_i,
    input  logic                      is_full_i,
    input  logic                      head_finished_i,
    input  logic [DEST_ADDR_SIZE-1:0] head_dest_addr_i,
    input  logic [INS_TYPE_SIZE-1:0]  head_ins_type_i,
    output logic [ROB_ADDR_SIZE-1:0]  rd_rob_id_o,
    input  logic [DATA_WIDTH-1:0]     result_data_i,
    input  logic [MEM_ADDR_WIDTH-1:0] result_addr_i,
    output logic                      commit_head_o,
    output logic                      rf_we_o,
    output logic [DEST_ADDR_SIZE-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      mem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_ack_i,
    output logic                      halted_o,
    output logic [31:0]               retired_count_o
);

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StStoreWait = 2'd1,
        StHalted    = 2'd2
    } state_e;

    localparam logic [INS_TYPE_SIZE-1:0] TypeAlu    = INS_TYPE_SIZE'(0);
    localparam logic [INS_TYPE_SIZE-1:0] TypeStore  = INS_TYPE_SIZE'(1);
    localparam logic [INS_TYPE_SIZE-1:0] TypeNoDest = INS_TYPE_SIZE'(2);
    localparam logic [INS_TYPE_SIZE-1:0] TypeHalt   = INS_TYPE_SIZE'(3);

    state_e                      state_q, state_d;
    logic                        mem_req_q, mem_req_d;
    logic [MEM_ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
    logic                        halted_q, halted_d;
    logic [31:0]                 retired_count_q, retired_count_d;

    logic rob_empty;
    logic head_ready;
    logic commit;
    logic we;

    // A full ROB has head == tail as well, so is_full disambiguates.
    assign rob_empty  = (head_id_i == tail_id_i) && !is_full_i;
    assign head_ready = !rob_empty && head_finished_i;

    assign rd_rob_id_o     = head_id_i;
    assign rf_waddr_o      = head_dest_addr_i;
    assign rf_wdata_o      = result_data_i;
    assign commit_head_o   = commit;
    assign rf_we_o         = we;
    assign mem_req_o       = mem_req_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign halted_o        = halted_q;
    assign retired_count_o = retired_count_q;

    // Next-state and commit/write pulses.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        halted_d    = halted_q;
        commit      = 1'b0;
        we          = 1'b0;
        unique case (state_q)
            StRun: begin
                if (head_ready) begin
                    case (head_ins_type_i)
                        TypeAlu: begin
                            commit = 1'b1;
                            we     = 1'b1;
                        end
                        TypeStore: begin
                            // Store commits only once memory has accepted it.
                            mem_req_d   = 1'b1;
                            mem_addr_d  = result_addr_i;
                            mem_wdata_d = result_data_i;
                            state_d     = StStoreWait;
                        end
                        TypeNoDest: begin
                            commit = 1'b1;
                        end
                        TypeHalt: begin
                            commit   = 1'b1;
                            halted_d = 1'b1;
                            state_d  = StHalted;
                        end
                        default: ;
                    endcase
                end
            end
            StStoreWait: begin
                if (mem_ack_i) begin
                    commit    = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StRun;
                end
            end
            StHalted: ;
            default: state_d = StRun;
        endcase
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_comb begin
        retired_count_d = retired_count_q + 32'(commit);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= StRun;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            halted_q        <= 1'b0;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            mem_req_q       <= mem_req_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            halted_q        <= halted_d;
            retired_count_q <= retired_count_d;
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Randomised bench for rob_commit_unit with an in-bench ROB and retire model.
module tb_rob_commit_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [4:0]  head_id_i, tail_id_i, rd_rob_id_o;
    logic        is_full_i, head_finished_i;
    logic [3:0]  head_dest_addr_i, rf_waddr_o;
    logic [1:0]  head_ins_type_i;
    logic [31:0] result_data_i, result_addr_i, rf_wdata_o;
    logic        commit_head_o, rf_we_o, mem_req_o, mem_ack_i, halted_o;
    logic [31:0] mem_addr_o, mem_wdata_o, retired_count_o;

    rob_commit_unit dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .head_id_i       (head_id_i),
        .tail_id_i       (tail_id_i),
        .is_full_i       (is_full_i),
        .head_finished_i (head_finished_i),
        .head_dest_addr_i(head_dest_addr_i),
        .head_ins_type_i (head_ins_type_i),
        .rd_rob_id_o     (rd_rob_id_o),
        .result_data_i   (result_data_i),
        .result_addr_i   (result_addr_i),
        .commit_head_o   (commit_head_o),
        .rf_we_o         (rf_we_o),
        .rf_waddr_o      (rf_waddr_o),
        .rf_wdata_o      (rf_wdata_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_ack_i       (mem_ack_i),
        .halted_o        (halted_o),
        .retired_count_o (retired_count_o)
    );

    always #5 clk_i = ~clk_i;

    // ROB contents as a circular buffer: entries head .. head+occ-1 are live.
    int          rob_type [32];
    logic [3:0]  rob_dest [32];
    logic [31:0] rob_data [32];
    logic [31:0] rob_addr [32];
    bit          rob_fin  [32];
    int          head_m, occ;
    bit          ack_m;

    // Retire-side expectations.
    bit          halted_m, pend_m;
    logic [31:0] pend_addr, pend_data, ret_m;
    bit          run_en;

    int          n_checks, n_fail;
    int          n_commit_seen;
    logic [35:0] wlog[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        head_id_i        = 5'(head_m);
        tail_id_i        = 5'((head_m + occ) % 32);
        is_full_i        = (occ == 32);
        head_finished_i  = rob_fin[head_m];
        head_dest_addr_i = rob_dest[head_m];
        head_ins_type_i  = 2'(rob_type[head_m]);
        result_data_i    = rob_data[head_m];
        result_addr_i    = rob_addr[head_m];
        mem_ack_i        = ack_m;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        drive();
    endtask

    task automatic push(input int t, input logic [3:0] d, input logic [31:0] data,
                        input logic [31:0] addr, input bit fin);
        int idx;
        idx = (head_m + occ) % 32;
        rob_type[idx] = t;
        rob_dest[idx] = d;
        rob_data[idx] = data;
        rob_addr[idx] = addr;
        rob_fin[idx]  = fin;
        occ++;
    endtask

    // Asynchronous reset asserted mid-cycle; registered outputs must clear at once.
    task automatic do_reset();
        @(posedge clk_i);
        #3;
        reset_i = 1'b1;
        #1;
        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata_o), 64'd0);
        chk("rst_halted", 64'(halted_o), 64'd0);
        chk("rst_count", 64'(retired_count_o), 64'd0);
        halted_m = 0;
        pend_m   = 0;
        ret_m    = '0;
        occ      = 0;
        ack_m    = 0;
        drive();
        #1;
        chk("rst_empty_commit", 64'(commit_head_o), 64'd0);
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    // Per-cycle comparison against the retire model, then advance the model.
    always @(negedge clk_i) begin
        bit ready, e_commit, e_we;
        if (run_en && !reset_i) begin
            ready    = (occ != 0) && rob_fin[head_m];
            e_commit = 0;
            e_we     = 0;
            if (halted_m) begin
                e_commit = 0;
            end else if (pend_m) begin
                e_commit = mem_ack_i;
            end else if (ready) begin
                case (rob_type[head_m])
                    0: begin e_commit = 1; e_we = 1; end
                    2, 3: e_commit = 1;
                    default: ;
                endcase
            end
            chk("commit_head", 64'(commit_head_o), 64'(e_commit));
            chk("rf_we", 64'(rf_we_o), 64'(e_we));
            chk("rf_waddr", 64'(rf_waddr_o), 64'(rob_dest[head_m]));
            chk("rf_wdata", 64'(rf_wdata_o), 64'(rob_data[head_m]));
            chk("rd_rob_id", 64'(rd_rob_id_o), 64'(head_m));
            chk("mem_req", 64'(mem_req_o), 64'(pend_m));
            if (pend_m) begin
                chk("mem_addr", 64'(mem_addr_o), 64'(pend_addr));
                chk("mem_wdata", 64'(mem_wdata_o), 64'(pend_data));
            end
            chk("halted", 64'(halted_o), 64'(halted_m));
            chk("retired_count", 64'(retired_count_o), 64'(ret_m));
            if (rf_we_o) wlog.push_back({rf_waddr_o, rf_wdata_o});
            if (commit_head_o) n_commit_seen++;

            if (pend_m) begin
                if (e_commit) pend_m = 0;
            end else if (!halted_m && ready && rob_type[head_m] == 1) begin
                pend_m    = 1;
                pend_addr = rob_addr[head_m];
                pend_data = rob_data[head_m];
            end
            if (e_commit) begin
                if (rob_type[head_m] == 3) halted_m = 1;
                head_m = (head_m + 1) % 32;
                occ--;
                ret_m = ret_m + 32'd1;
            end
        end
    end

    initial begin
        int c0, w0;
        for (int i = 0; i < 32; i++) begin
            rob_type[i] = 2; rob_dest[i] = '0; rob_data[i] = '0;
            rob_addr[i] = '0; rob_fin[i] = 0;
        end
        head_m = 0; occ = 0; ack_m = 0; run_en = 0;
        halted_m = 0; pend_m = 0; ret_m = '0; pend_addr = '0; pend_data = '0;
        n_checks = 0; n_fail = 0; n_commit_seen = 0;
        reset_i = 1'b1;
        drive();
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        run_en  = 1;

        // Reset with an empty ROB at index 0.
        do_reset();

        // Back-to-back ALU retires.
        wlog.delete();
        push(0, 4'd3, 32'h11, 32'h0, 1);
        push(0, 4'd5, 32'h22, 32'h0, 1);
        push(0, 4'd7, 32'h33, 32'h0, 1);
        drive();
        repeat (3) tick();
        chk("alu_drained", 64'(occ), 64'd0);
        tick();
        chk("alu_nwrites", 64'(wlog.size()), 64'd3);
        if (wlog.size() == 3) begin
            chk("alu_w0", 64'(wlog[0]), 64'h3_0000_0011);
            chk("alu_w1", 64'(wlog[1]), 64'h5_0000_0022);
            chk("alu_w2", 64'(wlog[2]), 64'h7_0000_0033);
        end
        chk("alu_count", 64'(retired_count_o), 64'd3);

        // Store acknowledged in the fourth request cycle.
        c0 = n_commit_seen;
        w0 = wlog.size();
        push(1, 4'd0, 32'hABCD, 32'h100, 1);
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_req_held", 64'(mem_req_o), 64'd1);
            chk("st_addr", 64'(mem_addr_o), 64'h100);
            chk("st_data", 64'(mem_wdata_o), 64'hABCD);
        end
        tick();
        ack_m = 1;
        drive();
        tick();
        ack_m = 0;
        drive();
        chk("st_commits", 64'(n_commit_seen - c0), 64'd1);
        chk("st_no_rf_we", 64'(wlog.size() - w0), 64'd0);
        chk("st_req_drop", 64'(mem_req_o), 64'd0);
        chk("st_count", 64'(retired_count_o), 64'd4);

        // Unfinished head blocks retirement.
        c0 = n_commit_seen;
        push(0, 4'd9, 32'h55, 32'h0, 0);
        drive();
        repeat (5) tick();
        chk("unfin_no_commit", 64'(n_commit_seen - c0), 64'd0);
        rob_fin[head_m] = 1;
        drive();
        tick();
        chk("unfin_commit", 64'(n_commit_seen - c0), 64'd1);

        // Full ROB starting at index 31, drained through the wrap point.
        do_reset();
        head_m = 31;
        for (int i = 0; i < 32; i++) push(2, 4'(i), 32'(i), 32'h0, 1);
        drive();
        c0 = n_commit_seen;
        for (int i = 0; i < 40 && occ != 0; i++) tick();
        chk("wrap_drained", 64'(occ), 64'd0);
        repeat (3) tick();
        chk("wrap_commits", 64'(n_commit_seen - c0), 64'd32);
        chk("wrap_head", 64'(head_id_i), 64'd31);
        chk("wrap_count", 64'(retired_count_o), 64'd32);

        // HALT freezes retirement until reset.
        do_reset();
        c0 = n_commit_seen;
        push(0, 4'd1, 32'hA1, 32'h0, 1);
        push(3, 4'd0, 32'h0, 32'h0, 1);
        push(0, 4'd2, 32'hA2, 32'h0, 1);
        drive();
        repeat (8) tick();
        chk("halt_commits", 64'(n_commit_seen - c0), 64'd2);
        chk("halt_flag", 64'(halted_o), 64'd1);
        chk("halt_left", 64'(occ), 64'd1);
        do_reset();
        chk("halt_cleared", 64'(halted_o), 64'd0);

        // Randomised traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if ((halted_m && ($urandom % 8 == 0)) || (pend_m && ($urandom % 60 == 0))) begin
                do_reset();
            end
            if (occ < 32 && ($urandom % 3 != 0)) begin
                int t;
                t = ($urandom % 64 == 0) ? 3 : int'($urandom % 3);
                push(t, 4'($urandom), $urandom, $urandom, bit'($urandom % 2));
            end
            if (occ > 0 && ($urandom % 2 == 0)) begin
                rob_fin[(head_m + int'($urandom % occ)) % 32] = 1;
            end
            ack_m = bit'($urandom % 2);
            drive();
        end
        tick();
        run_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
